issue_stage: RTL
================

Name: issue_stage

Overview:
- Dual-issue in-order issue stage between decode and the ID/EX pipeline registers of pipe 0 and pipe 1.
- Accepts a two-slot decoded bundle and detects intra-bundle conflicts. On a conflict it splits the bundle over two cycles.
- Applies load-use stalls from each pipe's forwarding unit and drives the registered ID/EX fields, including bubbles, for both pipes.

Parameters:
- AWIDTH, 5, register address width (matches header.vh)
- PCWIDTH, 32, program counter width
- CWIDTH, 16, opaque per-instruction control word width (ALU op, imm select, etc.)
- CNTWIDTH, 16, width of the performance counters

Ports:
- i_clk input 1 clock, rising edge
- i_rst_n input 1 synchronous active-low reset
- i_bundle_valid input 1 decode bundle present
- o_bundle_ready output 1 bundle accepted this cycle when high together with i_bundle_valid
- i_s{k}_valid input 1 slot k holds an instruction (k=0,1)
- i_s{k}_pc input PCWIDTH slot k PC
- i_s{k}_rs1, i_s{k}_rs2, i_s{k}_rd input AWIDTH slot k register addresses
- i_s{k}_regwrite, i_s{k}_memread, i_s{k}_memwrite input 1 slot k control bits
- i_s{k}_ctrl input CWIDTH slot k opaque control
- o_cand_p{k}_rs1, o_cand_p{k}_rs2 output AWIDTH combinational candidate source addresses for pipe k's forwarding unit
- i_stall_p{k} input 1 load-use stall from pipe k's forwarding unit
- i_flush input 1 branch-redirect flush
- o_p{k}_valid, o_p{k}_pc, o_p{k}_rs1, o_p{k}_rs2, o_p{k}_rd, o_p{k}_regwrite, o_p{k}_memread, o_p{k}_memwrite, o_p{k}_ctrl output (widths as inputs) registered ID/EX fields of pipe k
- o_split_cnt output CNTWIDTH saturating count of split bundles
- o_stall_cnt output CNTWIDTH saturating count of stall cycles

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst_n is synchronous and active-low.
- Reset (i_rst_n=0 at an edge): all o_p{k}_* = 0, state=S_PASS, hold buffer invalid, both counters = 0.
- Bubble: valid, regwrite, memread and memwrite all 0. Other fields are don't-care but are driven to 0.
- States:
  - S_PASS: candidate = incoming bundle (slot k → pipe k).
  - S_SPLIT: candidate = held slot 1 on pipe 1; pipe 0 gets a bubble.
- Conflict (S_PASS only, both slots valid). Any one of the following:
  - s0 regwrite && s0_rd!=0 && (s1_rs1==s0_rd || s1_rs2==s0_rd)
  - s0 regwrite && s1 regwrite && s0_rd==s1_rd && s0_rd!=0
  - (s0 memread|memwrite) && (s1 memread|memwrite)
- o_cand_p{k}_* are driven combinationally from the candidate and do not depend on i_stall_p{k}.
- Effective stall: stall = (cand0 valid && i_stall_p0) || (cand1 valid && i_stall_p1). A stall input on an empty pipe is ignored.
- Priority: reset > flush > stall > issue.
- Flush: at the next edge both pipes get bubbles, the hold buffer is invalidated, state→S_PASS. o_bundle_ready=0 in the flush cycle.
- Stall cycle: both pipes get bubbles, state and hold buffer are unchanged, o_bundle_ready=0, o_stall_cnt increments. No partial issue.
- S_PASS, bundle valid, no conflict:
  - o_bundle_ready=1.
  - Next edge: pipe k loads slot k, or a bubble if slot k is invalid.
- S_PASS, bundle valid, conflict:
  - o_bundle_ready=1.
  - Pipe 0 loads slot 0, pipe 1 loads a bubble.
  - Slot 1 is copied into the hold buffer; state→S_SPLIT; o_split_cnt increments.
- S_SPLIT:
  - o_bundle_ready=0.
  - With no stall: pipe 1 loads the held instruction, pipe 0 loads a bubble, state→S_PASS.
- S_PASS with i_bundle_valid=0: o_bundle_ready=1 and bubbles are issued.
- A bundle with both slots invalid is accepted and produces bubbles.
- Latency: one cycle from acceptance to ID/EX. A split bundle completes in two cycles plus any stall cycles.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- header.vh gains: CWIDTH, PCWIDTH, state encodings ISSUE_S_PASS=1'b0 and ISSUE_S_SPLIT=1'b1, and the bubble constant.
- One sub-module, issue_conflict_check: pure combinational slot-0/slot-1 conflict detect, reusable by a future 4-wide variant.
- The ID/EX registers stay inline in issue_stage.

Test Plan:
- Independent pair: s0 add r3←r1,r2 and s1 sub r6←r4,r5 → next cycle both pipes valid, rd 3 and 6; ready stays 1; o_split_cnt=0.
- RAW: s0 rd=3 regwrite, s1 rs1=3:
  - Cycle 1: pipe0 valid rd3, pipe1 bubble, ready=0.
  - Cycle 2: pipe0 bubble, pipe1 valid, state S_PASS.
  - o_split_cnt=1.
- r0 exemption: s0 writes r0 and s1 reads r0 → no split. Dual memory op (s0 lw, s1 sw) → split as in the RAW case.
- Stall: i_stall_p0=1 for 2 cycles with a valid pair → 2 bubble cycles, ready=0, o_stall_cnt=2, pair issued on the 3rd cycle. i_stall_p1=1 with slot 1 invalid → ignored.
- Flush in S_SPLIT → held instruction dropped, next cycle bubbles on both pipes, state S_PASS, ready=1 the cycle after. Same check with i_rst_n=0 mid-split, plus counters cleared.
- Counter saturation: preload by forcing 2^CNTWIDTH−1 splits, then one more split → o_split_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/issue_stage_pkg.sv
// Shared types and constants for the dual-issue stage: widths, FSM encoding
// and the ID/EX payload with its bubble value.
package issue_stage_pkg;

  localparam int unsigned AWIDTH       = 5;
  localparam int unsigned PCWIDTH      = 32;
  localparam int unsigned CWIDTH       = 16;
  localparam int unsigned CNTWIDTH_DEF = 16;

  typedef enum logic {
    ISSUE_S_PASS  = 1'b0,
    ISSUE_S_SPLIT = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic               valid;
    logic [PCWIDTH-1:0] pc;
    logic [AWIDTH-1:0]  rs1;
    logic [AWIDTH-1:0]  rs2;
    logic [AWIDTH-1:0]  rd;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic [CWIDTH-1:0]  ctrl;
  } issue_instr_t;

  localparam issue_instr_t ISSUE_BUBBLE = '0;

endpackage

// File: rtl/issue_conflict_check.sv
// Combinational intra-bundle hazard detect between an older slot (s0) and a
// younger slot (s1): RAW on s0's destination, WAW, or two memory operations.
module issue_conflict_check
  import issue_stage_pkg::*;
(
  input  logic              i_s0_valid,
  input  logic [AWIDTH-1:0] i_s0_rd,
  input  logic              i_s0_regwrite,
  input  logic              i_s0_memread,
  input  logic              i_s0_memwrite,
  input  logic              i_s1_valid,
  input  logic [AWIDTH-1:0] i_s1_rs1,
  input  logic [AWIDTH-1:0] i_s1_rs2,
  input  logic [AWIDTH-1:0] i_s1_rd,
  input  logic              i_s1_regwrite,
  input  logic              i_s1_memread,
  input  logic              i_s1_memwrite,
  output logic              o_conflict
);

  logic s0_writes_c;
  logic raw_c;
  logic waw_c;
  logic mem_c;

  // r0 is hardwired zero, so writes to it never create a dependency.
  assign s0_writes_c = i_s0_regwrite && (i_s0_rd != AWIDTH'(0));
  assign raw_c       = s0_writes_c && ((i_s1_rs1 == i_s0_rd) || (i_s1_rs2 == i_s0_rd));
  assign waw_c       = s0_writes_c && i_s1_regwrite && (i_s1_rd == i_s0_rd);
  assign mem_c       = (i_s0_memread || i_s0_memwrite) && (i_s1_memread || i_s1_memwrite);

  assign o_conflict  = i_s0_valid && i_s1_valid && (raw_c || waw_c || mem_c);

endmodule

// File: rtl/issue_stage.sv
// Dual-issue in-order issue stage: splits conflicting bundles over two cycles,
// applies load-use stalls and flushes, and drives the ID/EX registers of both pipes.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int unsigned CNTWIDTH = CNTWIDTH_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_bundle_valid,
  output logic                o_bundle_ready,
  input  logic                i_s0_valid,
  input  logic [PCWIDTH-1:0]  i_s0_pc,
  input  logic [AWIDTH-1:0]   i_s0_rs1,
  input  logic [AWIDTH-1:0]   i_s0_rs2,
  input  logic [AWIDTH-1:0]   i_s0_rd,
  input  logic                i_s0_regwrite,
  input  logic                i_s0_memread,
  input  logic                i_s0_memwrite,
  input  logic [CWIDTH-1:0]   i_s0_ctrl,
  input  logic                i_s1_valid,
  input  logic [PCWIDTH-1:0]  i_s1_pc,
  input  logic [AWIDTH-1:0]   i_s1_rs1,
  input  logic [AWIDTH-1:0]   i_s1_rs2,
  input  logic [AWIDTH-1:0]   i_s1_rd,
  input  logic                i_s1_regwrite,
  input  logic                i_s1_memread,
  input  logic                i_s1_memwrite,
  input  logic [CWIDTH-1:0]   i_s1_ctrl,
  output logic [AWIDTH-1:0]   o_cand_p0_rs1,
  output logic [AWIDTH-1:0]   o_cand_p0_rs2,
  output logic [AWIDTH-1:0]   o_cand_p1_rs1,
  output logic [AWIDTH-1:0]   o_cand_p1_rs2,
  input  logic                i_stall_p0,
  input  logic                i_stall_p1,
  input  logic                i_flush,
  output logic                o_p0_valid,
  output logic [PCWIDTH-1:0]  o_p0_pc,
  output logic [AWIDTH-1:0]   o_p0_rs1,
  output logic [AWIDTH-1:0]   o_p0_rs2,
  output logic [AWIDTH-1:0]   o_p0_rd,
  output logic                o_p0_regwrite,
  output logic                o_p0_memread,
  output logic                o_p0_memwrite,
  output logic [CWIDTH-1:0]   o_p0_ctrl,
  output logic                o_p1_valid,
  output logic [PCWIDTH-1:0]  o_p1_pc,
  output logic [AWIDTH-1:0]   o_p1_rs1,
  output logic [AWIDTH-1:0]   o_p1_rs2,
  output logic [AWIDTH-1:0]   o_p1_rd,
  output logic                o_p1_regwrite,
  output logic                o_p1_memread,
  output logic                o_p1_memwrite,
  output logic [CWIDTH-1:0]   o_p1_ctrl,
  output logic [CNTWIDTH-1:0] o_split_cnt,
  output logic [CNTWIDTH-1:0] o_stall_cnt
);

  issue_state_e  state_q, state_d;
  issue_instr_t  hold_q, hold_d;
  issue_instr_t  p0_q, p0_d;
  issue_instr_t  p1_q, p1_d;
  logic [CNTWIDTH-1:0] split_cnt_q, stall_cnt_q;
  logic          split_inc_c, stall_inc_c;

  issue_instr_t  slot0_c, slot1_c;
  issue_instr_t  cand0_c, cand1_c;
  logic          conflict_c;
  logic          stall_c;
  logic          ready_c;

  // Pack decode slots; an invalid slot is a clean bubble so it issues no side effects.
  always_comb begin
    slot0_c = ISSUE_BUBBLE;
    slot1_c = ISSUE_BUBBLE;
    if (i_s0_valid) begin
      slot0_c.valid    = 1'b1;
      slot0_c.pc       = i_s0_pc;
      slot0_c.rs1      = i_s0_rs1;
      slot0_c.rs2      = i_s0_rs2;
      slot0_c.rd       = i_s0_rd;
      slot0_c.regwrite = i_s0_regwrite;
      slot0_c.memread  = i_s0_memread;
      slot0_c.memwrite = i_s0_memwrite;
      slot0_c.ctrl     = i_s0_ctrl;
    end
    if (i_s1_valid) begin
      slot1_c.valid    = 1'b1;
      slot1_c.pc       = i_s1_pc;
      slot1_c.rs1      = i_s1_rs1;
      slot1_c.rs2      = i_s1_rs2;
      slot1_c.rd       = i_s1_rd;
      slot1_c.regwrite = i_s1_regwrite;
      slot1_c.memread  = i_s1_memread;
      slot1_c.memwrite = i_s1_memwrite;
      slot1_c.ctrl     = i_s1_ctrl;
    end
  end

  // Candidate instructions presented to the forwarding units this cycle.
  always_comb begin
    cand0_c = ISSUE_BUBBLE;
    cand1_c = ISSUE_BUBBLE;
    if (state_q == ISSUE_S_SPLIT) begin
      cand1_c = hold_q;
    end else if (i_bundle_valid) begin
      cand0_c = slot0_c;
      cand1_c = slot1_c;
    end
  end

  assign o_cand_p0_rs1 = cand0_c.rs1;
  assign o_cand_p0_rs2 = cand0_c.rs2;
  assign o_cand_p1_rs1 = cand1_c.rs1;
  assign o_cand_p1_rs2 = cand1_c.rs2;

  issue_conflict_check u_conflict (
    .i_s0_valid    (slot0_c.valid),
    .i_s0_rd       (slot0_c.rd),
    .i_s0_regwrite (slot0_c.regwrite),
    .i_s0_memread  (slot0_c.memread),
    .i_s0_memwrite (slot0_c.memwrite),
    .i_s1_valid    (slot1_c.valid),
    .i_s1_rs1      (slot1_c.rs1),
    .i_s1_rs2      (slot1_c.rs2),
    .i_s1_rd       (slot1_c.rd),
    .i_s1_regwrite (slot1_c.regwrite),
    .i_s1_memread  (slot1_c.memread),
    .i_s1_memwrite (slot1_c.memwrite),
    .o_conflict    (conflict_c)
  );

  // A stall request only matters when its pipe has something to issue.
  assign stall_c = (cand0_c.valid && i_stall_p0) || (cand1_c.valid && i_stall_p1);

  // Next state, ID/EX payloads and bundle handshake; flush beats stall beats issue.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    p0_d        = ISSUE_BUBBLE;
    p1_d        = ISSUE_BUBBLE;
    ready_c     = 1'b0;
    split_inc_c = 1'b0;
    stall_inc_c = 1'b0;
    if (i_flush) begin
      state_d = ISSUE_S_PASS;
      hold_d  = ISSUE_BUBBLE;
    end else if (stall_c) begin
      stall_inc_c = 1'b1;
    end else begin
      case (state_q)
        ISSUE_S_PASS: begin
          ready_c = 1'b1;
          if (i_bundle_valid) begin
            p0_d = cand0_c;
            if (conflict_c) begin
              hold_d      = cand1_c;
              state_d     = ISSUE_S_SPLIT;
              split_inc_c = 1'b1;
            end else begin
              p1_d = cand1_c;
            end
          end
        end
        ISSUE_S_SPLIT: begin
          p1_d    = hold_q;
          hold_d  = ISSUE_BUBBLE;
          state_d = ISSUE_S_PASS;
        end
        default: begin
          state_d = ISSUE_S_PASS;
          hold_d  = ISSUE_BUBBLE;
        end
      endcase
    end
  end

  assign o_bundle_ready = ready_c;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ISSUE_S_PASS;
      hold_q      <= ISSUE_BUBBLE;
      p0_q        <= ISSUE_BUBBLE;
      p1_q        <= ISSUE_BUBBLE;
      split_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      if (split_inc_c && (split_cnt_q != {CNTWIDTH{1'b1}})) begin
        split_cnt_q <= split_cnt_q + CNTWIDTH'(1);
      end
      if (stall_inc_c && (stall_cnt_q != {CNTWIDTH{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNTWIDTH'(1);
      end
    end
  end

  assign o_p0_valid    = p0_q.valid;
  assign o_p0_pc       = p0_q.pc;
  assign o_p0_rs1      = p0_q.rs1;
  assign o_p0_rs2      = p0_q.rs2;
  assign o_p0_rd       = p0_q.rd;
  assign o_p0_regwrite = p0_q.regwrite;
  assign o_p0_memread  = p0_q.memread;
  assign o_p0_memwrite = p0_q.memwrite;
  assign o_p0_ctrl     = p0_q.ctrl;

  assign o_p1_valid    = p1_q.valid;
  assign o_p1_pc       = p1_q.pc;
  assign o_p1_rs1      = p1_q.rs1;
  assign o_p1_rs2      = p1_q.rs2;
  assign o_p1_rd       = p1_q.rd;
  assign o_p1_regwrite = p1_q.regwrite;
  assign o_p1_memread  = p1_q.memread;
  assign o_p1_memwrite = p1_q.memwrite;
  assign o_p1_ctrl     = p1_q.ctrl;

  assign o_split_cnt = split_cnt_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule
